audio_rd_sched: RTL and testbench

Receive-side audio read scheduler in the pixel-clock domain. Drains the 12-bit receive audio FIFO (written by `gmii2fifo24` at 125 MHz) in fixed 32-word bursts during horizontal blanking, once per line. It paces bursts from the block-count field carried in each word and reports per-frame audio presence to the HDMI data-island encoder.

---
 rtl/audio_pkg.sv | 16 +
 rtl/audio_presence.sv | 29 ++
 rtl/audio_rd_sched.sv | 145 ++++++++++++++
 tb/tb_audio_rd_sched.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared audio definitions used by both the receive read scheduler and the
// transmit-side audio packer.
package audio_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    GAP  = 2'd2
  } rd_state_t;

  localparam int BURST_WORDS = 32;
  localparam int BURST_GAP   = 4;
  localparam int BLK_MSB     = 11;
  localparam int BLK_LSB     = 8;

endpackage

// File: rtl/audio_presence.sv
// Per-frame audio presence detector: remembers whether the FIFO held data at
// any point during a frame and publishes that at the next frame start.
module audio_presence
  import audio_pkg::*;
(
  input  logic        fifo_clk,
  input  logic        sys_rst,
  input  logic [11:0] vcnt,
  input  logic        aempty,
  output logic        audio_on
);

  logic ck;

  // Frame-start handoff publishes the collected flag and restarts collection;
  // the clear takes priority over a same-cycle non-empty observation.
  always_ff @(posedge fifo_clk) begin
    if (sys_rst) begin
      ck       <= 1'b0;
      audio_on <= 1'b0;
    end else if (vcnt == 12'd0) begin
      audio_on <= ck;
      ck       <= 1'b0;
    end else if (!aempty) begin
      ck <= 1'b1;
    end
  end

endmodule

// File: rtl/audio_rd_sched.sv
// Receive-side audio read scheduler: drains the audio FIFO in fixed bursts
// during horizontal blanking, paced by the block count carried in each word.
module audio_rd_sched
  import audio_pkg::*;
#(
  parameter int START_H     = 1530,
  parameter int MAX_BURSTS  = 3,
  parameter int BURST_WORDS = audio_pkg::BURST_WORDS,
  parameter int BURST_GAP   = audio_pkg::BURST_GAP
) (
  input  logic        fifo_clk,
  input  logic        sys_rst,
  input  logic [11:0] hcnt,
  input  logic [11:0] vcnt,
  input  logic        vde,
  input  logic        aempty,
  input  logic [11:0] adout,
  output logic        rd_en,
  output logic        busy,
  output logic [3:0]  burst_num,
  output logic        audio_on,
  output logic        underflow
);

  localparam int CNT_W = $clog2(BURST_WORDS + BURST_GAP);
  localparam logic [CNT_W-1:0] CNT_RD_LAST = CNT_W'(BURST_WORDS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(BURST_WORDS + BURST_GAP - 1);
  localparam logic [11:0]      START_H_C   = 12'(START_H);
  localparam logic [3:0]       MAX_BURST_C = 4'(MAX_BURSTS);

  // Burst counter never wraps; it sticks at its all-ones cap.
  function automatic logic [3:0] sat_inc_bursts(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  // Slot counter never runs past the last gap slot.
  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
    return (v == CNT_LAST) ? v : v + CNT_W'(1);
  endfunction

  rd_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       bursts_q, bursts_d;
  logic             rd_en_d;
  logic             underflow_d;
  logic             init_q;
  logic [3:0]       blk_left_p1;
  logic             armed;

  // Reads are allowed only in blanking, with data present, once video was seen.
  assign armed = ~vde & ~aempty & init_q;
  assign busy  = (state_q != IDLE);

  // Next-state and read-enable decode; any loss of 'armed' aborts the sequence.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rd_en_d     = 1'b0;
    underflow_d = underflow;
    bursts_d    = (hcnt == 12'd1) ? 4'd0 : bursts_q;
    case (state_q)
      IDLE: begin
        if (armed && hcnt == START_H_C) begin
          state_d  = READ;
          cnt_d    = '0;
          bursts_d = 4'd1;
          rd_en_d  = 1'b1;
        end
      end
      READ: begin
        // An empty FIFO in a read slot drops the slot and ends the sequence.
        if (!armed) begin
          state_d = IDLE;
          cnt_d   = '0;
          if (aempty) underflow_d = 1'b1;
        end else if (cnt_q == CNT_RD_LAST) begin
          state_d = GAP;
          cnt_d   = sat_inc_cnt(cnt_q);
        end else begin
          cnt_d   = sat_inc_cnt(cnt_q);
          rd_en_d = 1'b1;
        end
      end
      GAP: begin
        if (!armed) begin
          state_d = IDLE;
          cnt_d   = '0;
          if (aempty) underflow_d = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          // blk_left_p1 holds the word seen one slot earlier.
          if (blk_left_p1 != 4'd0 && bursts_q < MAX_BURST_C) begin
            state_d  = READ;
            cnt_d    = '0;
            bursts_d = sat_inc_bursts(bursts_q);
            rd_en_d  = 1'b1;
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = sat_inc_cnt(cnt_q);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Control registers: FSM, slot/burst counters, init latch and line report.
  always_ff @(posedge fifo_clk) begin
    if (sys_rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bursts_q  <= 4'd0;
      rd_en     <= 1'b0;
      underflow <= 1'b0;
      init_q    <= 1'b0;
      burst_num <= 4'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bursts_q  <= bursts_d;
      rd_en     <= rd_en_d;
      underflow <= underflow_d;
      if (vde) init_q <= 1'b1;
      if (hcnt == 12'd1) burst_num <= bursts_q;
    end
  end

  // ---- stage p1: block-count field of the FIFO word, one cycle late ----
  always_ff @(posedge fifo_clk) begin
    blk_left_p1 <= adout[BLK_MSB:BLK_LSB];
  end

  audio_presence u_presence (
    .fifo_clk (fifo_clk),
    .sys_rst  (sys_rst),
    .vcnt     (vcnt),
    .aempty   (aempty),
    .audio_on (audio_on)
  );

endmodule

// File: tb/tb_audio_rd_sched.sv
// Directed bench for audio_rd_sched with a sequence-position reference model.
module tb_audio_rd_sched;

  localparam int START_H = 1530;
  localparam int MAXB    = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] hcnt, vcnt, adout;
  logic        vde, aempty;
  logic        rd_en, busy, audio_on, underflow;
  logic [3:0]  burst_num;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  audio_rd_sched #(.START_H(START_H), .MAX_BURSTS(MAXB)) dut (
    .fifo_clk  (clk),
    .sys_rst   (rst),
    .hcnt      (hcnt),
    .vcnt      (vcnt),
    .vde       (vde),
    .aempty    (aempty),
    .adout     (adout),
    .rd_en     (rd_en),
    .busy      (busy),
    .burst_num (burst_num),
    .audio_on  (audio_on),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Reference model: a running sequence is a position counter; every 36-slot
  // period reads in its first 32 slots and may chain at its last slot.
  bit m_init, m_act, m_rd, m_under, m_ck, m_aon;
  int m_pos, m_bursts, m_bnum, m_blk;

  always @(posedge clk) begin : model
    bit armed;
    int nb;
    armed = !vde && !aempty && m_init;
    if (rst) begin
      m_init = 0; m_act = 0; m_rd = 0; m_under = 0; m_ck = 0; m_aon = 0;
      m_pos = 0; m_bursts = 0; m_bnum = 0;
    end else begin
      nb = (hcnt == 12'd1) ? 0 : m_bursts;
      if (hcnt == 12'd1) m_bnum = m_bursts;
      if (m_act) begin
        if (!armed) begin
          m_act = 0; m_rd = 0;
          if (aempty) m_under = 1;
        end else if (m_pos % 36 == 35) begin
          if (m_blk > 0 && m_bursts < MAXB) begin
            m_pos++; nb = m_bursts + 1; m_rd = 1;
          end else begin
            m_act = 0; m_rd = 0;
          end
        end else begin
          m_pos++;
          m_rd = (m_pos % 36) < 32;
        end
      end else if (armed && hcnt == 12'(START_H)) begin
        m_act = 1; m_pos = 0; nb = 1; m_rd = 1;
      end
      m_bursts = nb;
      if (vde) m_init = 1;
      if (vcnt == 12'd0) begin
        m_aon = m_ck; m_ck = 0;
      end else if (!aempty) begin
        m_ck = 1;
      end
    end
    m_blk = int'(adout[11:8]);
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("rd_en", int'(rd_en), int'(m_rd));
      chk("busy", int'(busy), int'(m_act));
      chk("burst_num", int'(burst_num), m_bnum);
      chk("audio_on", int'(audio_on), int'(m_aon));
      chk("underflow", int'(underflow), int'(m_under));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    hcnt = (hcnt == 12'd1649) ? 12'd0 : hcnt + 12'd1;
  endtask

  // One blanking interval from hcnt 1500 through the next hcnt==1 latch.
  // mode 1: FIFO empties at slot 10; 2: vde pulse in first gap; 3: reset at slot 20.
  task automatic run_line(input int mode, output int nrd, output int first_h,
                          output int last_h);
    bit fired, pending;
    nrd = 0; first_h = -1; last_h = -1; fired = 0; pending = 0;
    hcnt = 12'd1500;
    for (int i = 0; i < 160; i++) begin
      tick();
      if (pending) begin
        case (mode)
          1: aempty = 1'b0;
          2: vde = 1'b0;
          3: begin
            rst = 1'b0;
            chk("rst_rd_en", int'(rd_en), 0);
            chk("rst_busy", int'(busy), 0);
            chk("rst_burst_num", int'(burst_num), 0);
            chk("rst_underflow", int'(underflow), 0);
            chk("rst_audio_on", int'(audio_on), 0);
          end
          default: ;
        endcase
        pending = 0;
      end
      if (rd_en) begin
        nrd++;
        if (first_h < 0) first_h = int'(hcnt);
        last_h = int'(hcnt);
      end
      if (!fired) begin
        if (mode == 1 && rd_en && nrd == 11) begin
          aempty = 1'b1; fired = 1; pending = 1;
        end else if (mode == 2 && !rd_en && nrd == 32) begin
          vde = 1'b1; fired = 1; pending = 1;
        end else if (mode == 3 && rd_en && nrd == 21) begin
          rst = 1'b1; fired = 1; pending = 1;
        end
      end
    end
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int nrd, fh, lh, seen;
    rst = 1'b1; vde = 1'b0; aempty = 1'b1; adout = 12'h000;
    hcnt = 12'd0; vcnt = 12'd5;
    tick();
    chk_en = 1'b1;
    tick(); tick();
    chk("reset_rd_en", int'(rd_en), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_burst_num", int'(burst_num), 0);
    chk("reset_audio_on", int'(audio_on), 0);
    chk("reset_underflow", int'(underflow), 0);
    rst = 1'b0;

    // No bursts before vde has been seen.
    aempty = 1'b0; adout = 12'h0AB;
    run_line(0, nrd, fh, lh);
    chk("pre_init_reads", nrd, 0);
    vde = 1'b1; tick(); vde = 1'b0; tick();

    // Single burst.
    run_line(0, nrd, fh, lh);
    chk("single_reads", nrd, 32);
    chk("single_first_h", fh, 1531);
    chk("single_last_h", lh, 1562);
    chk("single_burst_num", int'(burst_num), 1);

    // Chained bursts capped at three.
    adout = 12'h5CD;
    run_line(0, nrd, fh, lh);
    chk("chain_reads", nrd, 96);
    chk("chain_first_h", fh, 1531);
    chk("chain_last_h", lh, 1634);
    chk("chain_burst_num", int'(burst_num), 3);

    // vde interrupt during the first gap.
    run_line(2, nrd, fh, lh);
    chk("vde_reads", nrd, 32);
    chk("vde_last_h", lh, 1562);
    chk("vde_burst_num", int'(burst_num), 1);
    chk("vde_underflow", int'(underflow), 0);

    // FIFO empties at slot 10.
    adout = 12'h0AB;
    run_line(1, nrd, fh, lh);
    chk("empty_reads", nrd, 11);
    chk("empty_last_h", lh, 1541);
    chk("empty_underflow", int'(underflow), 1);
    chk("empty_busy", int'(busy), 0);
    run_line(0, nrd, fh, lh);
    chk("after_empty_reads", nrd, 32);
    chk("underflow_sticky", int'(underflow), 1);

    // Presence across two short frames.
    aempty = 1'b1; vcnt = 12'd0;
    repeat (3) tick();
    vcnt = 12'd1; aempty = 1'b0; tick(); aempty = 1'b1;
    repeat (5) tick();
    vcnt = 12'd0; seen = 0;
    for (int i = 0; i < 4; i++) begin tick(); if (audio_on) seen++; end
    chk("presence_on_cycles", seen, 1);
    vcnt = 12'd1;
    repeat (10) tick();
    vcnt = 12'd0; seen = 0;
    for (int i = 0; i < 4; i++) begin tick(); if (audio_on) seen++; end
    chk("presence_off_cycles", seen, 0);
    vcnt = 12'd5;

    // Reset mid-burst, then no burst until vde is seen again.
    aempty = 1'b0;
    run_line(3, nrd, fh, lh);
    chk("reset_mid_reads", nrd, 21);
    run_line(0, nrd, fh, lh);
    chk("post_reset_reads", nrd, 0);
    vde = 1'b1; tick(); vde = 1'b0; tick();
    run_line(0, nrd, fh, lh);
    chk("reinit_reads", nrd, 32);
    chk("reinit_burst_num", int'(burst_num), 1);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
